// File: rtl/sync_pkg.sv
// Shared definitions for the timer / sample FIFO / synchronizer slice.
// Provides the sample width, the sample type and the default FIFO depth.
package sync_pkg;

  localparam int unsigned DW            = 16;
  localparam int unsigned DEPTH_DEFAULT = 8;

  typedef logic [DW-1:0] sample_t;

endpackage

// File: rtl/sample_fifo_if.sv
// Sample FIFO data-path interface.
// Write side : wr_valid, wr_data (driven by the timer: t_valid, t_out)
// Read side  : rd_valid, rd_data (show-ahead head), rd_ready (consumer accept)
// master = timer/consumer environment, slave = the FIFO.
interface sample_fifo_if
  import sync_pkg::*;
#(
  parameter int unsigned DW = sync_pkg::DW
);

  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_ready;

  modport master (
    output wr_valid,
    output wr_data,
    output rd_ready,
    input  rd_valid,
    input  rd_data
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    input  rd_ready,
    output rd_valid,
    output rd_data
  );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DW register array with one synchronous write port and one
// asynchronous (combinational) read port. Contents are not reset.
// Ports: clk, we, waddr, wdata (write side); raddr, rdata (read side).
module fifo_mem
  import sync_pkg::*;
#(
  parameter int unsigned DW    = sync_pkg::DW,
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DW-1:0]            rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sample_fifo.sv
// Capture FIFO directly downstream of the 16-bit timer.
// Stores each (wr_valid, wr_data) sample, presents the head show-ahead on
// rd_data with a valid/ready handshake, and throttles the timer through t_en
// (run gated by almost-full) so the timer never overruns the FIFO.
// Ports: clk, rst (async, active-high), run, clr_ovf, t_en,
//        bus (slave: wr_valid/wr_data in, rd_valid/rd_data out, rd_ready in),
//        count (0..DEPTH), full, empty, overflow (sticky dropped-write flag).
module sample_fifo
  import sync_pkg::*;
#(
  parameter int unsigned DW     = sync_pkg::DW,
  parameter int unsigned DEPTH  = DEPTH_DEFAULT,
  parameter int unsigned AF_GAP = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   clr_ovf,
  output logic                   t_en,
  sample_fifo_if.slave           bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] cnt_q;
  logic          ovf_q;
  logic          push;
  logic          pop;
  logic          afull;

  // Occupancy flags come straight from the registered count, which is one
  // bit wider than the pointers so that full and empty stay distinct.
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign afull = (cnt_q >= CW'(DEPTH - AF_GAP));

  // No fall-through: a write into an empty FIFO is not visible to pop
  // until the following cycle. A write while full is dropped even when a
  // pop happens on the same edge.
  assign push = bus.wr_valid & ~full;
  assign pop  = ~empty & bus.rd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + CW'(1);
      end else if (pop && !push) begin
        cnt_q <= cnt_q - CW'(1);
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (bus.wr_valid && full) begin
        ovf_q <= 1'b1;
      end else if (clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

  fifo_mem #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wptr),
    .wdata (bus.wr_data),
    .raddr (rptr),
    .rdata (bus.rd_data)
  );

  assign bus.rd_valid = ~empty;
  assign count        = cnt_q;
  assign overflow     = ovf_q;
  assign t_en         = run & ~afull;

endmodule
